// File: rtl/face_result_fifo_if.sv
// Host-side record link: valid/ready handshake carrying one tagged record.
interface face_result_fifo_if #(
    parameter int DATA_W = 70
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (output out_valid, output out_data, input  out_ready);
    modport slave  (input  out_valid, input  out_data, output out_ready);
endinterface

// File: rtl/face_result_fifo.sv
// Result collector behind detect_face: queues tagged detection records in a
// first-word-fall-through FIFO and closes each frame with an EOF record that
// carries the accepted and dropped detection counts.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no frame open; detections ignored
// COLLECT  | frame open; detections queued while a non-EOF slot is free
// EOF_PEND | frame closed; EOF record waits for any free FIFO slot
module face_result_fifo #(
    parameter int COORD_W = 32,
    parameter int PYR_W   = 4,
    parameter int DEPTH   = 16,
    parameter int CNT_W   = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 frame_start,
    input  logic                 face_coords_ready,
    input  logic [2*COORD_W-1:0] face_coords,
    input  logic [PYR_W-1:0]     pyramid_number,
    input  logic                 vj_pipeline_done,
    face_result_fifo_if.master   link,
    output logic                 busy,
    output logic                 overflow,
    output logic                 err_start
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = 2 + PYR_W + 2 * COORD_W;

    // Detections may only use DEPTH-1 slots so the EOF always finds room.
    localparam logic [CW-1:0]    LIMIT_DET = CW'(DEPTH - 1);
    localparam logic [CW-1:0]    LIMIT_EOF = CW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        EOF_PEND = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [DW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic [CNT_W-1:0] det_cnt, drop_cnt;

    logic             push, pop;
    logic [DW-1:0]    push_data;
    logic             det_inc, drop_inc, err_set, frame_open;
    logic [DW-1:0]    det_rec, eof_rec;

    assign det_rec = {2'b01, pyramid_number,
                      face_coords[COORD_W-1:0], face_coords[2*COORD_W-1:COORD_W]};
    assign eof_rec = {2'b10, {PYR_W{1'b0}}, COORD_W'(det_cnt), COORD_W'(drop_cnt)};

    assign link.out_valid = (count != '0);
    assign link.out_data  = mem[rd_ptr];
    assign pop            = link.out_valid & link.out_ready;
    assign busy           = (state != IDLE);

    // Frame state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state and push selection; push decisions use the pre-pop count.
    always_comb begin
        state_nxt  = state;
        push       = 1'b0;
        push_data  = '0;
        det_inc    = 1'b0;
        drop_inc   = 1'b0;
        err_set    = 1'b0;
        frame_open = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_nxt  = COLLECT;
                    frame_open = 1'b1;
                end
            end
            COLLECT: begin
                if (frame_start) err_set = 1'b1;
                if (face_coords_ready) begin
                    if (count < LIMIT_DET) begin
                        push      = 1'b1;
                        push_data = det_rec;
                        det_inc   = 1'b1;
                    end else begin
                        drop_inc  = 1'b1;
                    end
                end
                if (vj_pipeline_done) state_nxt = EOF_PEND;
            end
            EOF_PEND: begin
                if (frame_start) err_set = 1'b1;
                if (count < LIMIT_EOF) begin
                    push      = 1'b1;
                    push_data = eof_rec;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Per-frame saturating counters and sticky status flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            det_cnt   <= '0;
            drop_cnt  <= '0;
            overflow  <= 1'b0;
            err_start <= 1'b0;
        end else begin
            if (frame_open) begin
                det_cnt  <= '0;
                drop_cnt <= '0;
                overflow <= 1'b0;
            end else begin
                if (det_inc && det_cnt != CNT_MAX)   det_cnt  <= det_cnt + 1'b1;
                if (drop_inc && drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + 1'b1;
                if (drop_inc)                        overflow <= 1'b1;
            end
            if (err_set) err_start <= 1'b1;
        end
    end

    // FIFO storage, wrapping pointers and occupancy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_face_result_fifo.sv
// Directed bench for face_result_fifo with default parameters.
module tb_face_result_fifo;
    localparam int COORD_W = 32;
    localparam int PYR_W   = 4;
    localparam int DW      = 2 + PYR_W + 2 * COORD_W;

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic                 frame_start;
    logic                 face_coords_ready;
    logic [2*COORD_W-1:0] face_coords;
    logic [PYR_W-1:0]     pyramid_number;
    logic                 vj_pipeline_done;
    logic                 busy, overflow, err_start;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    logic [DW-1:0] exp_q[$];
    logic          prev_stalled;
    logic [DW-1:0] prev_data;

    face_result_fifo_if #(.DATA_W(DW)) link ();

    face_result_fifo #(
        .COORD_W(COORD_W), .PYR_W(PYR_W), .DEPTH(16), .CNT_W(16)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .frame_start      (frame_start),
        .face_coords_ready(face_coords_ready),
        .face_coords      (face_coords),
        .pyramid_number   (pyramid_number),
        .vj_pipeline_done (vj_pipeline_done),
        .link             (link),
        .busy             (busy),
        .overflow         (overflow),
        .err_start        (err_start)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] det(input int pyr, input int row, input int col);
        det = {2'b01, PYR_W'(pyr), COORD_W'(row), COORD_W'(col)};
    endfunction

    function automatic logic [DW-1:0] eof(input int dets, input int drops);
        eof = {2'b10, {PYR_W{1'b0}}, COORD_W'(dets), COORD_W'(drops)};
    endfunction

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic drive_det(input int pyr, input int row, input int col);
        face_coords_ready = 1'b1;
        pyramid_number    = PYR_W'(pyr);
        face_coords       = {COORD_W'(col), COORD_W'(row)};
    endtask

    task automatic idle_inputs();
        frame_start       = 1'b0;
        face_coords_ready = 1'b0;
        vj_pipeline_done  = 1'b0;
        face_coords       = '0;
        pyramid_number    = '0;
    endtask

    task automatic expect_pop(input string tag, input logic [DW-1:0] exp);
        int n = 0;
        link.out_ready = 1'b1;
        while (!link.out_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, ".valid"}, 80'(link.out_valid), 80'(1'b1));
        check({tag, ".data"}, 80'(link.out_data), 80'(exp));
        tick();
        link.out_ready = 1'b0;
    endtask

    // One cycle of the wrap test: consumer checks happen before the edge.
    task automatic wrap_step(input logic fs, input logic d, input logic dn, input int f);
        idle_inputs();
        frame_start      = fs;
        vj_pipeline_done = dn;
        if (d) begin
            drive_det(f % 16, f, 1000 + f);
            exp_q.push_back(det(f % 16, f, 1000 + f));
        end
        if (dn) exp_q.push_back(eof(1, 0));
        link.out_ready = cyc[0];
        if (prev_stalled && link.out_valid)
            check($sformatf("wrap.stable.c%0d", cyc), 80'(link.out_data), 80'(prev_data));
        prev_stalled = 1'b0;
        if (link.out_valid && link.out_ready) begin
            if (exp_q.size() == 0)
                check($sformatf("wrap.extra.c%0d", cyc), 80'(link.out_valid), 80'(1'b0));
            else
                check($sformatf("wrap.rec.c%0d", cyc), 80'(link.out_data), 80'(exp_q.pop_front()));
        end else if (link.out_valid) begin
            prev_stalled = 1'b1;
            prev_data    = link.out_data;
        end
        tick();
    endtask

    initial begin
        reset_n        = 1'b0;
        link.out_ready = 1'b0;
        prev_stalled   = 1'b0;
        prev_data      = '0;
        idle_inputs();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("rst.valid", 80'(link.out_valid), 80'(0));
        check("rst.busy", 80'(busy), 80'(0));
        check("rst.overflow", 80'(overflow), 80'(0));
        check("rst.err", 80'(err_start), 80'(0));
        check("rst.data", 80'(link.out_data), 80'(0));

        // Basic frame
        frame_start = 1'b1; tick(); idle_inputs();
        check("basic.busy_open", 80'(busy), 80'(1));
        drive_det(2, 10, 20); tick();
        drive_det(2, 11, 21); tick();
        drive_det(2, 12, 22); tick();
        idle_inputs(); vj_pipeline_done = 1'b1; tick(); idle_inputs();
        check("basic.busy_pend", 80'(busy), 80'(1));
        tick();
        check("basic.busy_done", 80'(busy), 80'(0));
        expect_pop("basic.d0", det(2, 10, 20));
        expect_pop("basic.d1", det(2, 11, 21));
        expect_pop("basic.d2", det(2, 12, 22));
        expect_pop("basic.eof", eof(3, 0));
        check("basic.empty", 80'(link.out_valid), 80'(0));

        // Overflow: 20 detections against a stalled host
        frame_start = 1'b1; tick(); idle_inputs();
        for (int i = 0; i < 20; i++) begin
            drive_det(i % 16, 100 + i, 200 + i);
            tick();
        end
        idle_inputs();
        check("ovf.flag", 80'(overflow), 80'(1));
        vj_pipeline_done = 1'b1; tick(); idle_inputs();
        tick();
        check("ovf.busy", 80'(busy), 80'(0));

        // Pending EOF: FIFO holds 16 entries, next frame closes immediately
        frame_start = 1'b1; tick(); idle_inputs();
        check("pend.ovf_clear", 80'(overflow), 80'(0));
        vj_pipeline_done = 1'b1; tick(); idle_inputs();
        tick(); tick(); tick();
        check("pend.held", 80'(busy), 80'(1));
        expect_pop("pend.d0", det(0, 100, 200));
        check("pend.after_pop", 80'(busy), 80'(1));
        tick();
        check("pend.pushed", 80'(busy), 80'(0));
        for (int i = 1; i < 15; i++)
            expect_pop($sformatf("ovf.d%0d", i), det(i % 16, 100 + i, 200 + i));
        expect_pop("ovf.eof", eof(15, 5));
        expect_pop("pend.eof", eof(0, 0));
        check("pend.empty", 80'(link.out_valid), 80'(0));

        // Coincident detection and done
        frame_start = 1'b1; tick(); idle_inputs();
        drive_det(3, 7, 8); vj_pipeline_done = 1'b1; tick(); idle_inputs();
        tick();
        expect_pop("coin.det", det(3, 7, 8));
        expect_pop("coin.eof", eof(1, 0));

        // Protocol error: frame_start while collecting
        frame_start = 1'b1; tick(); idle_inputs();
        drive_det(1, 1, 1); tick(); idle_inputs();
        frame_start = 1'b1; tick(); idle_inputs();
        check("err.flag", 80'(err_start), 80'(1));
        check("err.busy", 80'(busy), 80'(1));
        drive_det(1, 2, 2); tick(); idle_inputs();
        vj_pipeline_done = 1'b1; tick(); idle_inputs();
        tick();
        expect_pop("err.d0", det(1, 1, 1));
        expect_pop("err.d1", det(1, 2, 2));
        expect_pop("err.eof", eof(2, 0));
        check("err.sticky", 80'(err_start), 80'(1));

        // Asynchronous reset with 5 records queued
        frame_start = 1'b1; tick(); idle_inputs();
        for (int i = 0; i < 4; i++) begin
            drive_det(5, 50 + i, 60 + i);
            tick();
        end
        idle_inputs(); vj_pipeline_done = 1'b1; tick(); idle_inputs();
        tick();
        check("arst.pre_valid", 80'(link.out_valid), 80'(1));
        reset_n = 1'b0;
        #1;
        check("arst.valid", 80'(link.out_valid), 80'(0));
        check("arst.busy", 80'(busy), 80'(0));
        check("arst.overflow", 80'(overflow), 80'(0));
        check("arst.err", 80'(err_start), 80'(0));
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        check("arst.empty", 80'(link.out_valid), 80'(0));

        // Wrap-around with 50% host readiness
        for (int f = 0; f < 40; f++) begin
            wrap_step(1'b1, 1'b0, 1'b0, f);
            wrap_step(1'b0, 1'b1, 1'b0, f);
            wrap_step(1'b0, 1'b0, 1'b1, f);
            wrap_step(1'b0, 1'b0, 1'b0, f);
        end
        idle_inputs();
        link.out_ready = 1'b1;
        for (int n = 0; n < 40 && exp_q.size() != 0; n++) begin
            if (link.out_valid)
                check($sformatf("wrap.drain.n%0d", n), 80'(link.out_data), 80'(exp_q.pop_front()));
            tick();
        end
        link.out_ready = 1'b0;
        check("wrap.q_empty", 80'(exp_q.size()), 80'(0));
        check("wrap.fifo_empty", 80'(link.out_valid), 80'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
